ntt_sdf_stage_ctrl: RTL and testbench
=====================================

# ntt_sdf_stage_ctrl

Sequencer for one single-path delay-feedback (SDF) NTT stage: FIFO delay line, two input/output muxes, butterfly and twiddle multiplier. It replaces free-running, hard-coded counter decoding with a frame-aware FSM. The FSM accepts samples under a valid/ready handshake and generates FIFO push/pop, mux selects, butterfly enable and twiddle ROM address. It also produces output valid/last flags aligned to the multiplier result.

## Interface
- N, 16: points per frame; power of 2, N ≥ 2·D.
- D, 2: stage delay, equal to the FIFO depth; power of 2.
- MUL_LAT, 1: multiplier latency in cycles, from operand to result.
- TW_AW, $clog2(N): twiddle ROM address width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an incoming sample is present this cycle.
- in_ready  out  1  the stage accepts a sample this cycle.
- push  out  1  FIFO write.
- pop  out  1  FIFO read.
- sel1  out  1  FIFO write mux: 0 = incoming sample, 1 = butterfly negative output.
- sel2  out  1  multiplier input mux: 0 = FIFO output, 1 = butterfly positive output.
- bf_enable  out  1  butterfly active.
- tw_addr  out  TW_AW  twiddle ROM address for the current multiplier operand.
- out_valid  out  1  multiplier result valid (delayed by MUL_LAT).
- out_last  out  1  last result of the frame (delayed by MUL_LAT).
- frame_done  out  1  one-cycle pulse, coincident with out_last.

## Operation
- States: IDLE, RUN, DRAIN. Sample counter k: $clog2(N) bits. Drain counter j: $clog2(D)+1 bits.
- accept = in_valid & in_ready.
- in_ready = 1 in IDLE and RUN, 0 in DRAIN and while rst is asserted.
- Block position p = k mod 2D. Phase A: p < D. Phase B: p ≥ D.
- IDLE → RUN on the first accept, which is processed as k=0 in that same cycle.
- Control outputs are combinational from state, k, j and accept. Without accept in RUN, all controls are 0 and k holds (stall).
- RUN, accept, k < D (fill):
  - push=1, sel1=0, pop=0, no operand.
- RUN, accept, phase B:
  - push=1, sel1=1, pop=1, bf_enable=1, sel2=1.
  - tw_addr = 0.
  - Operand issued.
- RUN, accept, phase A, k ≥ 2D:
  - push=1, sel1=0, pop=1, bf_enable=0, sel2=0.
  - tw_addr = (p)·(N/(2D)).
  - Operand issued.
- Frame end: an accept with k = N−1 sets k→0 and enters DRAIN, j→0.
- DRAIN, every cycle regardless of in_valid:
  - push=0, pop=1, sel2=0, bf_enable=0.
  - tw_addr = j·(N/(2D)).
  - Operand issued.
  - When j = D−1: mark last, go IDLE.
- In IDLE, outputs not otherwise stated are 0, and tw_addr = 0.
- An operand-issued bit and a last bit enter an MUL_LAT-deep shift register. Its outputs drive out_valid, out_last and frame_done.
- Exactly N operands are issued per frame.
- The FIFO never overflows: occupancy reaches D after fill and stays at D until DRAIN empties it.

## Timing
- Reset (asynchronous, immediate): state=IDLE, k=0, j=0, shift register cleared. out_valid, out_last and frame_done = 0; all combinational controls = 0; in_ready=0 while rst is high.
- Reset mid-frame abandons the frame. The FIFO shares rst, so the next frame restarts at fill.
- Result latency: MUL_LAT cycles after the operand-issue cycle.
- Frame cost: N accepts + D drain cycles. in_ready returns to 1 in the first IDLE cycle.
- Stalls do not advance the phase. The sequences of push, sel, tw_addr and out_valid pulses are identical with or without stalls, apart from the gaps.

## Test plan
- Reset: assert rst mid-cycle → in_ready, push, pop, out_valid and frame_done read 0 immediately, before the next clock edge. After release, in_ready=1 and state is IDLE.
- Continuous frame, N=16, D=2, MUL_LAT=1, in_valid=1 in cycles 0–15:
  - push in cycles 0–15; pop in cycles 2–17.
  - sel1=1 in cycles 2,3,6,7,10,11,14,15.
  - in_ready=0 in cycles 16–17.
  - out_valid in cycles 3–18; out_last and frame_done in cycle 18.
- Twiddle order, same run: tw_addr at the pop cycles = 0,0,0,4 repeated four times. sel2 = 1,1,0,0 repeated.
- Stall: in_valid=0 in cycles 5–7 of the frame → no push/pop in those cycles, out_valid gap of 3 cycles. Total out_valid count = 16 and the tw_addr sequence is unchanged.
- Reset at sample 9, then a fresh frame → the first pop occurs at the third accept. The full 16-result sequence matches the continuous-frame case.
- Back-to-back, in_valid held high for 40 cycles → accepts in cycles 0–15, 18–33 and 36–39. frame_done pulses in cycles 18 and 36.

Source files
------------

// File: rtl/ntt_sdf_stage_ctrl.sv
// Frame-aware sequencer for one single-path delay-feedback NTT stage.
// Drives FIFO push/pop, data-path muxes, butterfly enable, twiddle address and result flags.
module ntt_sdf_stage_ctrl #(
   parameter int N       = 16,
   parameter int D       = 2,
   parameter int MUL_LAT = 1,
   parameter int TW_AW   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             push,
   output logic             pop,
   output logic             sel1,
   output logic             sel2,
   output logic             bf_enable,
   output logic [TW_AW-1:0] tw_addr,
   output logic             out_valid,
   output logic             out_last,
   output logic             frame_done
);

   localparam int KW      = $clog2(N);
   localparam int JW      = $clog2(D) + 1;
   localparam int TW_STEP = N / (2 * D);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t             r_state, w_state_nxt;
   logic [KW-1:0]      r_k, w_k_nxt, w_p;
   logic [JW-1:0]      r_j, w_j_nxt;
   logic [MUL_LAT-1:0] r_vld_sr, r_last_sr;
   logic               w_accept, w_issue, w_last;

   assign in_ready = (r_state != ST_DRAIN) && !rst;
   assign w_accept = in_valid && in_ready;
   // Position inside the current 2D block; upper half is the butterfly phase.
   assign w_p      = r_k & KW'(2 * D - 1);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_j_nxt     = r_j;
      push        = 1'b0;
      pop         = 1'b0;
      sel1        = 1'b0;
      sel2        = 1'b0;
      bf_enable   = 1'b0;
      tw_addr     = '0;
      w_issue     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            if (w_accept) begin
               push = 1'b1;
               if (r_k >= KW'(D)) begin
                  pop     = 1'b1;
                  w_issue = 1'b1;
                  if (w_p >= KW'(D)) begin
                     sel1      = 1'b1;
                     sel2      = 1'b1;
                     bf_enable = 1'b1;
                  end else begin
                     tw_addr = TW_AW'(int'(w_p) * TW_STEP);
                  end
               end
               if (r_k == KW'(N - 1)) begin
                  w_state_nxt = ST_DRAIN;
                  w_k_nxt     = '0;
                  w_j_nxt     = '0;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_k_nxt     = r_k + KW'(1);
               end
            end
         end
         ST_DRAIN: begin
            pop     = 1'b1;
            w_issue = 1'b1;
            tw_addr = TW_AW'(int'(r_j) * TW_STEP);
            w_j_nxt = r_j + JW'(1);
            if (r_j == JW'(D - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
               w_j_nxt     = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_j       <= '0;
         r_vld_sr  <= '0;
         r_last_sr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         r_state   <= w_state_nxt;
         r_k       <= w_k_nxt;
         r_j       <= w_j_nxt;
         r_vld_sr  <= MUL_LAT'({r_vld_sr, w_issue});
         r_last_sr <= MUL_LAT'({r_last_sr, w_last});
      end
   end

   // Flags line up with the multiplier result MUL_LAT cycles after issue.
   assign out_valid  = r_vld_sr[MUL_LAT-1];
   assign out_last   = r_last_sr[MUL_LAT-1];
   assign frame_done = r_last_sr[MUL_LAT-1];

endmodule

// File: tb/tb_ntt_sdf_stage_ctrl.sv
// Self-checking bench for ntt_sdf_stage_ctrl: per-cycle comparison against a
// sample-count reference model, plus directed frame, stall, reset and back-to-back scenarios.
module tb_ntt_sdf_stage_ctrl;

   localparam int N       = 16;
   localparam int D       = 2;
   localparam int MUL_LAT = 1;
   localparam int TW_AW   = $clog2(N);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             push, pop, sel1, sel2, bf_enable;
   logic [TW_AW-1:0] tw_addr;
   logic             out_valid, out_last, frame_done;

   always #5 clk = ~clk;

   ntt_sdf_stage_ctrl #(.N(N), .D(D), .MUL_LAT(MUL_LAT), .TW_AW(TW_AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .push      (push),
      .pop       (pop),
      .sel1      (sel1),
      .sel2      (sel2),
      .bf_enable (bf_enable),
      .tw_addr   (tw_addr),
      .out_valid (out_valid),
      .out_last  (out_last),
      .frame_done(frame_done)
   );

   typedef struct packed {
      logic             rdy;
      logic             push;
      logic             pop;
      logic             sel1;
      logic             sel2;
      logic             bf;
      logic [TW_AW-1:0] tw;
      logic             ov;
      logic             ol;
      logic             fd;
   } ctl_t;

   ctl_t obs_q[$];
   ctl_t exp_q[$];
   ctl_t msk_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: samples accepted in this frame and drain cycles still owed.
   int   m_cnt;
   int   m_drain;
   bit   iss_q[$];
   bit   last_q[$];

   function automatic void model_reset();
      m_cnt   = 0;
      m_drain = 0;
      iss_q.delete();
      last_q.delete();
   endfunction

   function automatic void clear_log();
      obs_q.delete();
      exp_q.delete();
      msk_q.delete();
   endfunction

   // One clock cycle: drive in_valid, sample mid-cycle, log observed/expected/mask.
   task automatic tick(input bit v);
      ctl_t o, e, m;
      bit   acc, iss, lst;
      int   s, pos, j;
      in_valid = v;
      @(negedge clk);
      o.rdy  = in_ready;  o.push = push;     o.pop = pop;
      o.sel1 = sel1;      o.sel2 = sel2;     o.bf  = bf_enable;
      o.tw   = tw_addr;   o.ov   = out_valid; o.ol = out_last;
      o.fd   = frame_done;
      e = '0;
      m = '1;
      iss = 1'b0;
      lst = 1'b0;
      e.rdy = (m_drain == 0);
      acc = v && e.rdy;
      if (acc) begin
         s      = m_cnt;
         pos    = s % (2 * D);
         e.push = 1'b1;
         if (s < D) begin
            m.sel2 = 1'b0;
            m.bf   = 1'b0;
            m.tw   = '0;
         end else begin
            e.pop = 1'b1;
            iss   = 1'b1;
            if (pos >= D) begin
               e.sel1 = 1'b1;
               e.sel2 = 1'b1;
               e.bf   = 1'b1;
            end else begin
               e.tw = TW_AW'(pos * (N / (2 * D)));
            end
         end
         m_cnt++;
         if (m_cnt == N) begin
            m_cnt   = 0;
            m_drain = D;
         end
      end else if (m_drain > 0) begin
         j     = D - m_drain;
         e.pop = 1'b1;
         iss   = 1'b1;
         e.tw  = TW_AW'(j * (N / (2 * D)));
         lst   = (m_drain == 1);
         m_drain--;
      end
      if (iss_q.size() >= MUL_LAT) begin
         e.ov = iss_q[iss_q.size() - MUL_LAT];
         e.ol = last_q[last_q.size() - MUL_LAT];
         e.fd = e.ol;
      end
      iss_q.push_back(iss);
      last_q.push_back(lst);
      obs_q.push_back(o);
      exp_q.push_back(e);
      msk_q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({in_ready, push, pop, out_valid, frame_done} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=00000", {in_ready, push, pop, out_valid, frame_done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({in_ready, push, pop, out_valid, out_last, frame_done} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_release got=%b exp=100000",
                  {in_ready, push, pop, out_valid, out_last, frame_done});
      end
   endtask

   task automatic test_continuous();
      logic [19:0] pu, po, s1, nr, ov, fd;
      int          tw_seen[$];
      int          s2_seen[$];
      clear_log();
      for (int c = 0; c < 20; c++) tick(c < 16);
      foreach (obs_q[i]) begin
         checks++;
         if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failures++;
            $display("FAIL cont_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
         end
      end
      for (int c = 0; c < 20; c++) begin
         pu[c] = obs_q[c].push;
         po[c] = obs_q[c].pop;
         s1[c] = obs_q[c].sel1;
         nr[c] = !obs_q[c].rdy;
         ov[c] = obs_q[c].ov;
         fd[c] = obs_q[c].fd;
         if (obs_q[c].pop) begin
            tw_seen.push_back(int'(obs_q[c].tw));
            s2_seen.push_back(int'(obs_q[c].sel2));
         end
      end
      checks++;
      if (pu !== 20'h0FFFF) begin failures++; $display("FAIL cont_push got=%h exp=0ffff", pu); end
      checks++;
      if (po !== 20'h3FFFC) begin failures++; $display("FAIL cont_pop got=%h exp=3fffc", po); end
      checks++;
      if (s1 !== 20'h0CCCC) begin failures++; $display("FAIL cont_sel1 got=%h exp=0cccc", s1); end
      checks++;
      if (nr !== 20'h30000) begin failures++; $display("FAIL cont_notready got=%h exp=30000", nr); end
      checks++;
      if (ov !== 20'h7FFF8) begin failures++; $display("FAIL cont_out_valid got=%h exp=7fff8", ov); end
      checks++;
      if (fd !== 20'h40000) begin failures++; $display("FAIL cont_frame_done got=%h exp=40000", fd); end
      checks++;
      if (tw_seen.size() != 16) begin
         failures++;
         $display("FAIL cont_pop_count got=%0d exp=16", tw_seen.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (tw_seen[i] != ((i % 4 == 3) ? 4 : 0) || s2_seen[i] != ((i % 4 < 2) ? 1 : 0)) begin
               failures++;
               $display("FAIL cont_twiddle%0d got tw=%0d sel2=%0d exp tw=%0d sel2=%0d", i,
                        tw_seen[i], s2_seen[i], (i % 4 == 3) ? 4 : 0, (i % 4 < 2) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [22:0] pp, ov;
      int          tw_seen[$];
      int          nov;
      clear_log();
      for (int c = 0; c < 23; c++) tick((c < 5) || (c >= 8 && c <= 18));
      foreach (obs_q[i]) begin
         checks++;
         if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failures++;
            $display("FAIL stall_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
         end
      end
      nov = 0;
      for (int c = 0; c < 23; c++) begin
         pp[c] = obs_q[c].push | obs_q[c].pop;
         ov[c] = obs_q[c].ov;
         if (obs_q[c].ov) nov++;
         if (obs_q[c].pop) tw_seen.push_back(int'(obs_q[c].tw));
      end
      checks++;
      if (pp[7:5] !== 3'b000) begin failures++; $display("FAIL stall_quiet got=%b exp=000", pp[7:5]); end
      checks++;
      if (ov[9:5] !== 5'b10001) begin failures++; $display("FAIL stall_gap got=%b exp=10001", ov[9:5]); end
      checks++;
      if (nov != 16) begin failures++; $display("FAIL stall_out_count got=%0d exp=16", nov); end
      checks++;
      if (tw_seen.size() != 16) begin
         failures++;
         $display("FAIL stall_pop_count got=%0d exp=16", tw_seen.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (tw_seen[i] != ((i % 4 == 3) ? 4 : 0)) begin
               failures++;
               $display("FAIL stall_twiddle%0d got=%0d exp=%0d", i, tw_seen[i], (i % 4 == 3) ? 4 : 0);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int first_pop;
      int nov;
      int tw_seen[$];
      clear_log();
      for (int c = 0; c < 9; c++) tick(1'b1);
      in_valid = 1'b1;
      #2;
      checks++;
      if ({push, pop, out_valid} !== 3'b111) begin
         failures++;
         $display("FAIL midframe_pre got=%b exp=111", {push, pop, out_valid});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, push, pop, out_valid, frame_done} !== 5'b0) begin
         failures++;
         $display("FAIL midframe_reset got=%b exp=00000", {in_ready, push, pop, out_valid, frame_done});
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      clear_log();
      for (int c = 0; c < 20; c++) tick(c < 16);
      foreach (obs_q[i]) begin
         checks++;
         if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failures++;
            $display("FAIL fresh_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
         end
      end
      first_pop = -1;
      nov = 0;
      for (int c = 0; c < 20; c++) begin
         if (obs_q[c].pop && first_pop < 0) first_pop = c;
         if (obs_q[c].pop) tw_seen.push_back(int'(obs_q[c].tw));
         if (obs_q[c].ov) nov++;
      end
      checks++;
      if (first_pop != 2) begin failures++; $display("FAIL fresh_first_pop got=%0d exp=2", first_pop); end
      checks++;
      if (nov != 16 || tw_seen.size() != 16) begin
         failures++;
         $display("FAIL fresh_counts got ov=%0d pops=%0d exp=16", nov, tw_seen.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (tw_seen[i] != ((i % 4 == 3) ? 4 : 0)) begin
               failures++;
               $display("FAIL fresh_twiddle%0d got=%0d exp=%0d", i, tw_seen[i], (i % 4 == 3) ? 4 : 0);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] acc, acc_exp, fd, fd_exp;
      clear_log();
      for (int c = 0; c < 40; c++) tick(1'b1);
      foreach (obs_q[i]) begin
         checks++;
         if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failures++;
            $display("FAIL b2b_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
         end
      end
      for (int c = 0; c < 40; c++) begin
         acc[c]     = obs_q[c].rdy;
         fd[c]      = obs_q[c].fd;
         acc_exp[c] = (c <= 15) || (c >= 18 && c <= 33) || (c >= 36);
         fd_exp[c]  = (c == 18) || (c == 36);
      end
      checks++;
      if (acc !== acc_exp) begin failures++; $display("FAIL b2b_accepts got=%h exp=%h", acc, acc_exp); end
      checks++;
      if (fd !== fd_exp) begin failures++; $display("FAIL b2b_frame_done got=%h exp=%h", fd, fd_exp); end
   endtask

   task automatic test_random();
      clear_log();
      for (int c = 0; c < 400; c++) tick($urandom_range(0, 3) != 0);
      foreach (obs_q[i]) begin
         checks++;
         if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failures++;
            $display("FAIL rand_cycle%0d got=%h exp=%h", i, obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_stall();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
